code_sequencer: RTL and testbench

CODE_SEQUENCER -- requirements
Module: code_sequencer

---
 rtl/code_seq_pkg.sv | 18 +
 rtl/btn_debounce.sv | 62 ++++++
 rtl/code_sequencer.sv | 111 +++++++++++
 tb/tb_code_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_seq_pkg.sv
// Shared types and helpers for the code sequencer: state enum, code width
// and the binary-to-Gray conversion used by the CODE_SEQ_GRAY_EN build.
package code_seq_pkg;

  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HOLD   = 2'd2
  } seq_state_e;

  // Adjacent Gray codes differ in exactly one bit.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for a bouncing push-button.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with it; rise pulses in the cycle the level becomes 1.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer chain; sync_q[1] is the only version of btn used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Stability counter: any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/code_sequencer.sv
// 4-bit code sequencer stepped by a debounced button (MANUAL), a periodic
// tick plus the button (AUTO), or frozen (HOLD). Outputs are registered.
// Define CODE_SEQ_GRAY_EN to present the Gray code of the index on x3..x0.
module code_sequencer
  import code_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AUTO_PERIOD     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_btn,
  input  logic mode_auto,
  input  logic hold,
  output logic x3,
  output logic x2,
  output logic x1,
  output logic x0,
  output logic code_valid,
  output logic wrap
);

  localparam int unsigned PerW = $clog2(AUTO_PERIOD + 1);
  localparam logic [PerW-1:0] PerLast = PerW'(AUTO_PERIOD - 1);

  seq_state_e        state_q, state_d;
  logic [PerW-1:0]   per_q, per_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              btn_level, btn_rise;
  logic              step_evt, tick, advance;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (step_btn),
    .level(btn_level),
    .rise (btn_rise)
  );

  // A rise is only a step while the accepted level is actually high.
  assign step_evt = btn_rise & btn_level;

  // Mode selection, period counting and index advance.
  always_comb begin
    state_d = MANUAL;
    if (hold) begin
      state_d = HOLD;
    end else if (mode_auto) begin
      state_d = AUTO;
    end

    tick  = 1'b0;
    per_d = per_q;
    case (state_q)
      AUTO: begin
        if (per_q == PerLast) begin
          tick  = 1'b1;
          per_d = '0;
        end else begin
          per_d = per_q + PerW'(1);
        end
      end
      HOLD:    per_d = per_q;
      // MANUAL keeps the counter cleared so AUTO always starts a fresh period.
      default: per_d = '0;
    endcase

    // Tick and button in the same cycle still give a single step.
    advance = tick | (step_evt & (state_q != HOLD));
    idx_d   = advance ? idx_q + CODE_W'(1) : idx_q;
    valid_d = advance;
    wrap_d  = advance & (idx_q == {CODE_W{1'b1}});
`ifdef CODE_SEQ_GRAY_EN
    code_d  = bin2gray(idx_d);
`else
    code_d  = idx_d;
`endif
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      per_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign x3         = code_q[3];
  assign x2         = code_q[2];
  assign x1         = code_q[1];
  assign x0         = code_q[0];
  assign code_valid = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench for code_sequencer: a behavioural model tracks the
// expected code/code_valid/wrap every cycle; directed scenarios add literal
// expectations, then a randomized phase exercises mode, hold and button mixes.
module tb_code_sequencer;

  localparam int unsigned DC = 16;
  localparam int unsigned AP = 10;

`ifdef CODE_SEQ_GRAY_EN
  localparam logic [3:0] SEQ [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                      4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
  localparam logic [3:0] CODE3 = 4'b0010;
  localparam logic [3:0] CODE6 = 4'b0101;
`else
  localparam logic [3:0] CODE3 = 4'b0011;
  localparam logic [3:0] CODE6 = 4'b0110;
`endif

  logic clk = 1'b0;
  logic rst_n, step_btn, mode_auto, hold;
  logic x3, x2, x1, x0, code_valid, wrap;

  always #5 clk = ~clk;

  code_sequencer #(
    .DEBOUNCE_CYCLES(DC),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_btn  (step_btn),
    .mode_auto (mode_auto),
    .hold      (hold),
    .x3        (x3),
    .x2        (x2),
    .x1        (x1),
    .x0        (x0),
    .code_valid(code_valid),
    .wrap      (wrap)
  );

  int checks = 0;
  int failures = 0;
  int prints = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
    end
  endtask

  function automatic logic [3:0] enc(input int unsigned i);
    logic [3:0] b;
    b = i[3:0];
`ifdef CODE_SEQ_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // Button: raw -> two-sample delay -> accepted level flips once the last DC
  // delayed samples all disagree with it. Mode 0=manual 1=auto 2=hold.
  bit          m_s1 = 0, m_s2 = 0, m_lvl = 0, m_rise = 0;
  bit          m_hist[$];
  int          m_st = 0;
  int unsigned m_cnt = 0, m_idx = 0;
  bit          m_valid = 0, m_wrap = 0;
  logic [3:0]  m_code = 4'd0;
  int          m_coll = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_hist.delete();
      m_st = 0; m_cnt = 0; m_idx = 0; m_valid = 0; m_wrap = 0; m_code = 4'd0;
    end else begin
      bit sin, all_diff, tck, adv;
      sin = m_s2; m_s2 = m_s1; m_s1 = step_btn;
      m_hist.push_back(sin);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == DC);
      foreach (m_hist[k]) if (m_hist[k] == m_lvl) all_diff = 0;
      tck = (m_st == 1) && (m_cnt == AP - 1);
      adv = tck || (m_st != 2 && m_rise);
      if (tck && m_rise) m_coll++;
      m_rise = all_diff && !m_lvl;
      if (all_diff) begin
        m_lvl = !m_lvl;
        m_hist.delete();
      end
      if (m_st == 1) m_cnt = (m_cnt == AP - 1) ? 0 : m_cnt + 1;
      else if (m_st == 0) m_cnt = 0;
      m_st = hold ? 2 : (mode_auto ? 1 : 0);
      m_valid = adv;
      m_wrap  = adv && (m_idx == 15);
      if (adv) m_idx = (m_idx + 1) % 16;
      m_code = enc(m_idx);
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int cyc = 0, valid_cnt = 0, wrap_cnt = 0, last_vc = 0, prev_vc = 0;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    check("cyc_code", {x3, x2, x1, x0}, m_code);
    check("cyc_valid", code_valid, m_valid);
    check("cyc_wrap", wrap, m_wrap);
    if (code_valid) begin
      valid_cnt++;
      prev_vc = last_vc;
      last_vc = cyc;
    end
    if (wrap) wrap_cnt++;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    step_btn = 1'b1;
    cyc_wait(hi);
    step_btn = 1'b0;
    cyc_wait(lo);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_code"}, {x3, x2, x1, x0}, 0);
    check({tag, "_valid"}, code_valid, 0);
    check({tag, "_wrap"}, wrap, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  int vc, wc, k, f, cyc_rel, coll0;
  logic [3:0] prev_code;

  initial begin
    rst_n = 1'b0; step_btn = 1'b0; mode_auto = 1'b0; hold = 1'b0;
    cyc_wait(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    cyc_wait(2);

    // Bounce: 5 bounces of 3 cycles then 20 stable cycles -> one step.
    vc = valid_cnt;
    for (int i = 0; i < 5; i++) begin
      step_btn = 1'b1; cyc_wait(3);
      step_btn = 1'b0; cyc_wait(3);
    end
    press(20, 24);
    check("bounce_pulses", valid_cnt - vc, 1);
    check("bounce_code", {x3, x2, x1, x0}, 1);
    check("bounce_model_idx", m_idx, 1);

    // Manual wrap from a fresh reset.
    rst_n = 1'b0; cyc_wait(2); rst_n = 1'b1; cyc_wait(1);
    prev_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      vc = valid_cnt; wc = wrap_cnt;
      press(24, 24);
      check("wrap_pulse", valid_cnt - vc, 1);
      check("wrap_flag", wrap_cnt - wc, (i == 15) ? 1 : 0);
`ifdef CODE_SEQ_GRAY_EN
      check("gray_code", {x3, x2, x1, x0}, SEQ[i]);
      check("gray_onebit", $countones({x3, x2, x1, x0} ^ prev_code), 1);
`else
      check("bin_code", {x3, x2, x1, x0}, (i + 1) % 16);
`endif
      prev_code = {x3, x2, x1, x0};
    end

    // Auto: 35 cycles -> three ticks, 10 cycles apart.
    vc = valid_cnt;
    mode_auto = 1'b1;
    cyc_wait(35);
    check("auto_pulses", valid_cnt - vc, 3);
    check("auto_spacing", last_vc - prev_vc, AP);
    check("auto_code", {x3, x2, x1, x0}, CODE3);

    // Collision: line the debounced rise up with a tick.
    k = 0;
    while (m_cnt != 1 && k < 20) begin
      cyc_wait(1);
      k++;
    end
    check("align_found", (m_cnt == 1) ? 1 : 0, 1);
    vc = valid_cnt; coll0 = m_coll;
    step_btn = 1'b1;
    cyc_wait(20);
    check("coll_pulses", valid_cnt - vc, 2);
    check("coll_seen", m_coll - coll0, 1);
    check("coll_code", {x3, x2, x1, x0}, CODE6);
    step_btn = 1'b0;
    cyc_wait(24);

    // Hold for 50 cycles with a press inside, then resume the frozen period.
    vc = valid_cnt;
    hold = 1'b1;
    press(24, 24);
    cyc_wait(2);
    check("hold_pulses", valid_cnt - vc, 0);
    f = int'(m_cnt);
    cyc_rel = cyc;
    hold = 1'b0;
    cyc_wait(12);
    check("resume_cycle", last_vc, cyc_rel + 11 - f);

    // Reset mid-period and mid-debounce at code 6.
    mode_auto = 1'b0;
    rst_n = 1'b0; cyc_wait(2); rst_n = 1'b1; cyc_wait(1);
    for (int i = 0; i < 6; i++) press(24, 24);
    check("pre_reset_code", {x3, x2, x1, x0}, CODE6);
    mode_auto = 1'b1;
    cyc_wait(5);
    step_btn = 1'b1;
    cyc_wait(8);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    cyc_wait(1);
    step_btn = 1'b0; mode_auto = 1'b0;
    cyc_wait(2);
    rst_n = 1'b1;
    vc = valid_cnt;
    cyc_wait(30);
    check("post_reset_pulses", valid_cnt - vc, 0);
    check("post_reset_code", {x3, x2, x1, x0}, 0);

    // Randomized mix of button, mode and hold.
    for (int i = 0; i < 80; i++) begin
      step_btn  = ($urandom % 2) == 1;
      mode_auto = ($urandom % 3) != 0;
      hold      = ($urandom % 6) == 0;
      cyc_wait($urandom_range(1, 40));
    end
    step_btn = 1'b0; mode_auto = 1'b0; hold = 1'b0;
    cyc_wait(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
